vga_box_renderer: RTL



---
 rtl/vga_pkg.sv | 23 ++
 rtl/box_mover.sv | 51 +++++
 rtl/vga_box_renderer.sv | 73 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, colour constants, direction encoding and the bounce step helper.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;
  localparam logic [COLOR_W-1:0] GREEN = 12'h0F0;
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;
  typedef struct packed {
    logic                hit;
    logic [COORD_W-1:0]  pos;
  } axis_t;
  // lim is span-size; the extra bit keeps pos+step from wrapping near the far edge
  function automatic axis_t axis_step(input logic [COORD_W-1:0] pos, input dir_t dir,
                                      input logic [COORD_W-1:0] lim, input logic [COORD_W-1:0] step);
    axis_t r;
    r.hit = (dir == DIR_POS) ? (({1'b0, pos} + {1'b0, step}) > {1'b0, lim}) : (pos < step);
    r.pos = r.hit ? ((dir == DIR_POS) ? lim : '0) : ((dir == DIR_POS) ? pos + step : pos - step);
    return r;
  endfunction
endpackage

// File: rtl/box_mover.sv
// box_mover: box position, direction and colour state; steps once per frame and bounces off the edges.
module box_mover import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_frame_tick,
  input  logic               i_pause,
  input  logic [COLOR_W-1:0] i_sw,
  output logic [COORD_W-1:0] o_box_x,
  output logic [COORD_W-1:0] o_box_y,
  output logic [COLOR_W-1:0] o_box_color,
  output logic               o_bounce
);
  localparam logic [COORD_W-1:0] LIM_X = COORD_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] STP   = COORD_W'(STEP);
  logic [COORD_W-1:0] r_box_x, r_box_y;
  logic [COLOR_W-1:0] r_box_color;
  dir_t               r_dir_x, r_dir_y;
  logic               r_bounce;
  axis_t              w_ax, w_ay;
  assign w_ax = axis_step(r_box_x, r_dir_x, LIM_X, STP);
  assign w_ay = axis_step(r_box_y, r_dir_y, LIM_Y, STP);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_box_x     <= LIM_X >> 1;
      r_box_y     <= LIM_Y >> 1;
      r_dir_x     <= DIR_POS;
      r_dir_y     <= DIR_POS;
      r_box_color <= WHITE;
      r_bounce    <= 1'b0;
    end else begin
      r_bounce <= i_frame_tick && !i_pause && (w_ax.hit || w_ay.hit);
      if (i_frame_tick) r_box_color <= i_sw;
      if (i_frame_tick && !i_pause) begin
        r_box_x <= w_ax.pos;
        r_box_y <= w_ay.pos;
        r_dir_x <= w_ax.hit ? dir_t'(~r_dir_x) : r_dir_x;
        r_dir_y <= w_ay.hit ? dir_t'(~r_dir_y) : r_dir_y;
      end
    end
  end
  assign o_box_x     = r_box_x;
  assign o_box_y     = r_box_y;
  assign o_box_color = r_box_color;
  assign o_bounce    = r_bounce;
endmodule

// File: rtl/vga_box_renderer.sv
// vga_box_renderer: two-stage pixel pipeline drawing a bouncing box and a screen border,
// with syncs delayed to stay aligned with rgb.
module vga_box_renderer import vga_pkg::*; #(
  parameter int                 H_ACTIVE     = H_ACTIVE_DEF,
  parameter int                 V_ACTIVE     = V_ACTIVE_DEF,
  parameter int                 BOX_SIZE     = 32,
  parameter int                 STEP         = 2,
  parameter logic [COLOR_W-1:0] BG_COLOR     = BLACK,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = GREEN,
  parameter logic               SYNC_IDLE    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               active_video,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COLOR_W-1:0] sw,
  input  logic               pause,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [COLOR_W-1:0] rgb,
  output logic               bounce
);
  localparam logic [COORD_W:0] BS = (COORD_W+1)'(BOX_SIZE);
  logic [COORD_W-1:0] w_box_x, w_box_y;
  logic [COLOR_W-1:0] w_box_color, w_color;
  logic               w_frame_tick, w_in_box, w_border;
  logic               r_s1_active, r_s1_in_box, r_s1_border, r_s1_hs, r_s1_vs;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_hs, r_vs;
  // first pixel of vertical blanking: motion never lands inside a visible line
  assign w_frame_tick = p_tick && (x == '0) && (y == COORD_W'(V_ACTIVE));
  box_mover #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)
  ) u_mover (
    .clk(clk), .reset(reset), .i_frame_tick(w_frame_tick), .i_pause(pause), .i_sw(sw),
    .o_box_x(w_box_x), .o_box_y(w_box_y), .o_box_color(w_box_color), .o_bounce(bounce)
  );
  assign w_in_box = ({1'b0, x} >= {1'b0, w_box_x}) && ({1'b0, x} < {1'b0, w_box_x} + BS) &&
                    ({1'b0, y} >= {1'b0, w_box_y}) && ({1'b0, y} < {1'b0, w_box_y} + BS);
  assign w_border = (x == '0) || (x == COORD_W'(H_ACTIVE - 1)) ||
                    (y == '0) || (y == COORD_W'(V_ACTIVE - 1));
  always_comb begin
    w_color = !r_s1_active ? BLACK : r_s1_in_box ? w_box_color : r_s1_border ? BORDER_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_active <= 1'b0;
      r_s1_in_box <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_hs     <= SYNC_IDLE;
      r_s1_vs     <= SYNC_IDLE;
      r_rgb       <= BLACK;
      r_hs        <= SYNC_IDLE;
      r_vs        <= SYNC_IDLE;
    end else if (p_tick) begin
      r_s1_active <= active_video;
      r_s1_in_box <= w_in_box;
      r_s1_border <= w_border;
      r_s1_hs     <= hsync_in;
      r_s1_vs     <= vsync_in;
      r_rgb       <= w_color;
      r_hs        <= r_s1_hs;
      r_vs        <= r_s1_vs;
    end
  end
  assign rgb       = r_rgb;
  assign hsync_out = r_hs;
  assign vsync_out = r_vs;
endmodule
